// File: rtl/aemb_wbsel.sv
// AEMB2 memory/writeback stage: result select, big-endian load alignment and a load-ack stall with timeout.
// Define AEMB_WB_FWD_EN to enable operand-forward compares on fwd_a/fwd_b.
module aemb_wbsel #(
  parameter int TMO = 255
) (
  input  logic        gclk,
  input  logic        grst,
  input  logic        dena,
  input  logic [5:0]  x_opc,
  input  logic [4:0]  x_rd,
  input  logic        x_wre,
  input  logic [31:0] x_alu,
  input  logic [31:0] m_bsf,
  input  logic [31:0] m_mul,
  input  logic [31:0] dwb_dat_i,
  input  logic        dwb_ack_i,
  input  logic [4:0]  x_ra,
  input  logic [4:0]  x_rb,
  output logic        m_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_dat,
  output logic        w_berr,
  output logic        fwd_a,
  output logic        fwd_b
);

  localparam logic [5:0] OPC_MUL  = 6'o20;
  localparam logic [5:0] OPC_BS   = 6'o21;
  localparam bit         TMO_EN   = (TMO != 0);
  localparam logic [7:0] TMO_LAST = 8'((TMO > 0) ? TMO - 1 : 0);

  typedef enum logic [0:0] {ST_RUN, ST_LWAIT} state_t;

  state_t      state_q, state_d;
  logic [5:0]  m_opc_q, m_opc_d;
  logic [4:0]  m_rd_q, m_rd_d;
  logic        m_wre_q, m_wre_d;
  logic [31:0] m_alu_q, m_alu_d;
  logic        m_done_q, m_done_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_dat_q, rf_dat_d;
  logic        w_berr_q, w_berr_d;

  logic        m_is_ld;
  logic        ld_done;
  logic        advance;
  logic [31:0] ld_data;
  logic [31:0] exe_data;

  // m_done marks a load in M that already wrote back but could not leave M
  // (dena low or timeout stall); it must neither stall again nor write twice.
  assign m_is_ld = (m_opc_q[5:4] == 2'b11) && !m_opc_q[2] && !m_done_q;

  always_comb begin
    ld_data = 32'h0;
    case (m_opc_q[1:0])
      2'b00: begin
        case (m_alu_q[1:0])
          2'b00: ld_data = {24'h0, dwb_dat_i[31:24]};
          2'b01: ld_data = {24'h0, dwb_dat_i[23:16]};
          2'b10: ld_data = {24'h0, dwb_dat_i[15:8]};
          2'b11: ld_data = {24'h0, dwb_dat_i[7:0]};
        endcase
      end
      2'b01:   ld_data = m_alu_q[1] ? {16'h0, dwb_dat_i[15:0]} : {16'h0, dwb_dat_i[31:16]};
      2'b10:   ld_data = dwb_dat_i;
      default: ld_data = 32'h0;
    endcase
  end

  always_comb begin
    exe_data = m_alu_q;
    if (m_opc_q == OPC_BS) begin
      exe_data = m_bsf;
    end else if (m_opc_q == OPC_MUL) begin
      exe_data = m_mul;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_dat_d = rf_dat_q;
    w_berr_d = 1'b0;
    m_stall  = 1'b0;
    ld_done  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (m_is_ld) begin
          if (!dwb_ack_i) begin
            m_stall = 1'b1;
            state_d = ST_LWAIT;
            cnt_d   = 8'h0;
          end else begin
            rf_we_d  = m_wre_q;
            rf_rd_d  = m_rd_q;
            rf_dat_d = ld_data;
            ld_done  = 1'b1;
          end
        end else if (dena && !m_done_q) begin
          rf_we_d  = m_wre_q;
          rf_rd_d  = m_rd_q;
          rf_dat_d = exe_data;
        end
      end
      ST_LWAIT: begin
        m_stall = !dwb_ack_i;
        if (dwb_ack_i) begin
          rf_we_d  = m_wre_q;
          rf_rd_d  = m_rd_q;
          rf_dat_d = ld_data;
          state_d  = ST_RUN;
          ld_done  = 1'b1;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          w_berr_d = 1'b1;
          rf_we_d  = m_wre_q;
          rf_rd_d  = m_rd_q;
          rf_dat_d = 32'h0;
          state_d  = ST_RUN;
          ld_done  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign advance = dena && !m_stall;

  always_comb begin
    m_opc_d  = m_opc_q;
    m_rd_d   = m_rd_q;
    m_wre_d  = m_wre_q;
    m_alu_d  = m_alu_q;
    m_done_d = m_done_q | ld_done;
    if (advance) begin
      m_opc_d  = x_opc;
      m_rd_d   = x_rd;
      m_wre_d  = x_wre && (x_rd != 5'd0);
      m_alu_d  = x_alu;
      m_done_d = 1'b0;
    end
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q  <= ST_RUN;
      m_opc_q  <= 6'h0;
      m_rd_q   <= 5'h0;
      m_wre_q  <= 1'b0;
      m_alu_q  <= 32'h0;
      m_done_q <= 1'b0;
      cnt_q    <= 8'h0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= 5'h0;
      rf_dat_q <= 32'h0;
      w_berr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_opc_q  <= m_opc_d;
      m_rd_q   <= m_rd_d;
      m_wre_q  <= m_wre_d;
      m_alu_q  <= m_alu_d;
      m_done_q <= m_done_d;
      cnt_q    <= cnt_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_dat_q <= rf_dat_d;
      w_berr_q <= w_berr_d;
    end
  end

  assign rf_we  = rf_we_q;
  assign rf_rd  = rf_rd_q;
  assign rf_dat = rf_dat_q;
  assign w_berr = w_berr_q;

`ifdef AEMB_WB_FWD_EN
  assign fwd_a = rf_we_q && (rf_rd_q == x_ra);
  assign fwd_b = rf_we_q && (rf_rd_q == x_rb);
`else
  logic unused_fwd_src;
  assign unused_fwd_src = ^{x_ra, x_rb};
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

endmodule
